// File: rtl/rr_grant_arbiter.sv
// rtl/rr_grant_arbiter.sv - round-robin arbiter with registered one-hot grant and hold limit
//
// Purpose: shares one resource between N requesters. The owner keeps the grant
// while it holds req; after MAX_HOLD contended cycles the grant is forced to
// rotate to the next waiting requester. MAX_HOLD=0 disables the limit.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   req         per-requester request level [N]
//   grant       one-hot grant, zero when idle [N]
//   grant_idx   binary owner index, 0 when idle [$clog2(N)]
//   grant_valid high when any grant is asserted
//   hold_cnt    cycles the current owner has held the grant
module rr_grant_arbiter #(
    parameter  int N        = 4,
    parameter  int MAX_HOLD = 16,
    localparam int IW       = $clog2(N),
    localparam int HW       = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          grant_valid,
    output logic [HW-1:0] hold_cnt
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    // Counter value on which a contended owner is preempted, and the value the
    // counter saturates at (1 when the limit is disabled).
    localparam logic [HW-1:0] HOLD_LAST = HW'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
    localparam logic [HW-1:0] HOLD_SAT  = HW'((MAX_HOLD == 0) ? 1 : MAX_HOLD);

    logic [0:0]    state_q, state_d;
    logic [N-1:0]  grant_q, grant_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          valid_q, valid_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [IW-1:0] ptr_q, ptr_d;

    logic [N-1:0]  search_vec;
    logic [N-1:0]  others;
    logic [IW-1:0] winner;
    logic          do_arb;
    logic          owner_req;
    logic          hold_limit;

    // Rotate v right by p so v[p] lands at bit 0, take the lowest set bit,
    // then add p back modulo N to recover the absolute index.
    function automatic logic [IW-1:0] rr_pick(input logic [N-1:0] v, input logic [IW-1:0] p);
        logic [2*N-1:0] dbl;
        logic [N-1:0]   rot;
        logic [IW:0]    off;
        logic [IW:0]    sum;
        dbl = {v, v} >> p;
        rot = dbl[N-1:0];
        off = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) off = (IW + 1)'(i);
        end
        sum = off + {1'b0, p};
        if (sum >= (IW + 1)'(N)) sum = sum - (IW + 1)'(N);
        return sum[IW-1:0];
    endfunction

    assign others    = req & ~grant_q;
    assign owner_req = req[idx_q];
    // ">=" rather than "==" so an owner that saturated its counter while
    // uncontended is still preempted as soon as someone else starts waiting.
    assign hold_limit = (MAX_HOLD != 0) && (hold_q >= HOLD_LAST);
    assign winner     = rr_pick(search_vec, ptr_q);

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        idx_d      = idx_q;
        valid_d    = valid_q;
        hold_d     = hold_q;
        ptr_d      = ptr_q;
        search_vec = req;
        do_arb     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (|req) do_arb = 1'b1;
            end
            default: begin
                if (!owner_req) begin
                    // Release: the owner's bit is already low, so req itself
                    // is the set of remaining candidates.
                    if (|req) begin
                        do_arb = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        grant_d = '0;
                        idx_d   = '0;
                        valid_d = 1'b0;
                        hold_d  = '0;
                    end
                end else if (hold_limit && (|others)) begin
                    search_vec = others;
                    do_arb     = 1'b1;
                end else if (hold_q != HOLD_SAT) begin
                    hold_d = hold_q + 1'b1;
                end
            end
        endcase

        if (do_arb) begin
            state_d = ST_GRANT;
            grant_d = {{(N - 1){1'b0}}, 1'b1} << winner;
            idx_d   = winner;
            valid_d = 1'b1;
            hold_d  = '0;
            ptr_d   = (winner == IW'(N - 1)) ? '0 : winner + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            hold_q  <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            hold_q  <= hold_d;
            ptr_q   <= ptr_d;
        end
    end

    assign grant       = grant_q;
    assign grant_idx   = idx_q;
    assign grant_valid = valid_q;
    assign hold_cnt    = hold_q;

endmodule

// File: doc/rr_grant_arbiter.md
Name: rr_grant_arbiter

Overview:
- Round-robin arbiter sharing one NPU resource (e.g. a scratchpad or weight-buffer port) between N requesters.
- Grants are registered and one-hot, with a binary index alongside.
- Ownership persists while the owner holds its request.
- A hold limit forces rotation when other requesters are waiting, which bounds starvation.
- Sits between requesting engines and the resource mux; grant_idx drives the mux select directly.

Parameters:
- N, 4, number of requesters (N ≥ 2).
- MAX_HOLD, 16, max consecutive grant cycles before forced rotation if others are pending; 0 = unlimited.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- req  input  N  per-requester request level; held high for the whole transaction.
- grant  output  N  one-hot grant (all-zero when idle), registered.
- grant_idx  output  $clog2(N)  encoded owner index, 0 when idle, registered.
- grant_valid  output  1  high when any grant is asserted, registered.
- hold_cnt  output  $clog2(MAX_HOLD+1) (min 1)  cycles the current owner has held, registered.

Behaviour:
- Clocking and reset:
  - One clock domain: clk.
  - Reset is asynchronous and active-high: rst asserts outputs immediately; release is synchronous to clk.
  - Reset values: grant=0, grant_idx=0, grant_valid=0, hold_cnt=0, internal state=IDLE, ptr=0.
- Rotating priority: ptr (width $clog2(N)) marks the highest-priority index. Candidate search order is ptr, ptr+1, …, N-1, 0, …, ptr-1 (wrap modulo N). It is implemented by rotating the request vector by ptr, priority-encoding lowest-index-first, and adding ptr back modulo N.
- States:
  - IDLE: if req≠0, the winner is chosen from req. Next cycle: state=GRANT, grant=one-hot(winner), grant_idx=winner, grant_valid=1, hold_cnt=0, ptr=winner+1 mod N. If req=0, stay in IDLE.
  - GRANT, owner release (req[grant_idx]=0 sampled):
    - If other requests are pending, the winner among them is granted the next cycle, with no idle bubble, hold_cnt=0 and ptr updated.
    - Otherwise the next cycle is IDLE with all outputs at 0.
  - GRANT, forced rotation: MAX_HOLD≠0, hold_cnt==MAX_HOLD-1, req[grant_idx]=1, and any other req high. The owner is excluded from the search. The next cycle grants the winner among the others, with hold_cnt=0 and ptr updated.
  - GRANT, otherwise: grant is held and hold_cnt increments, saturating at MAX_HOLD (at 1 when MAX_HOLD=0).
- Latency: request to grant is 1 cycle. Release to regrant or idle is 1 cycle. The grant lasts at most MAX_HOLD cycles while contended.
- Invariants:
  - grant is always zero or one-hot.
  - grant_valid == |grant.
  - grant_idx is consistent with grant.
  - An owner never sees grant deasserted while its req stays high, except by forced rotation.
- Simultaneous events:
  - Owner release and hold-limit in the same cycle: treat as a release; the owner is already excluded because its req is low.
  - New requests arriving during GRANT do not affect the grant until release or rotation.
- A preempted requester that keeps req high is re-granted later through normal rotation.
- Reset asserted mid-grant: grant drops to 0 asynchronously with no completion. After release, arbitration restarts from ptr=0.

Test Plan:
- N=4, MAX_HOLD=4. Reset, then req=4'b0101 at cycle 0 -> cycle 1: grant=0001, grant_idx=0, grant_valid=1, hold_cnt=0.
- Continue: req[0] dropped at cycle 3, req=0100 -> cycle 4: grant=0100, grant_idx=2, no zero cycle between. Then req=0 -> next cycle: grant=0, grant_valid=0.
- req=0011 held constant from cycle 0 -> grant=0001 on cycles 1–4 (hold_cnt 0..3), 0010 on cycles 5–8, 0001 on cycles 9–12.
- Wrap-around: req=1001 with ptr=3 from a prior grant to index 2 -> grant_idx=3. After release, with req[0] still high -> grant_idx=0.
- req=0010 held alone for 20 cycles -> grant stays 0010 throughout; hold_cnt saturates at 4; no rotation.
- rst pulsed mid-grant for a half-cycle between edges -> grant=0 and grant_valid=0 immediately, before the next edge. After release with req=1000 -> grant=1000 one cycle later.
